// File: rtl/mux_project_sel_ctrl.sv
// Project-select controller: accepts a project address, sequences a quiesce/switch/reset
// handover with one-hot ena, broadcasts iw and registers the selected wrapper's ow to the pads.
module mux_project_sel_ctrl #(
  parameter int NUM_PROJ   = 32,
  parameter int ADDR_W     = 5,
  parameter int RST_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   addr_valid,
  output logic                   addr_ready,
  output logic                   addr_err,
  output logic                   busy,
  output logic [ADDR_W-1:0]      active_addr,
  input  logic [7:0]             ui_in,
  input  logic [7:0]             uio_in,
  output logic [NUM_PROJ-1:0]    ena,
  output logic [17:0]            iw,
  input  logic [NUM_PROJ*24-1:0] ow_bus,
  output logic [7:0]             uo_out,
  output logic [7:0]             uio_out,
  output logic [7:0]             uio_oe
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RUN, QUIESCE, SWITCH, RESET} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_ok;
  logic [CNT_W-1:0]  cnt;
  logic              proj_rst_n;
  logic              accept;
  logic              addr_ok;
  logic [23:0]       sel_ow;

  function automatic logic [NUM_PROJ-1:0] onehot(input logic [ADDR_W-1:0] a);
    return NUM_PROJ'(1) << a;
  endfunction

  assign accept  = addr_valid && addr_ready;
  assign addr_ok = int'(addr_i) < NUM_PROJ;
  assign iw      = {uio_in, ui_in, proj_rst_n, clk};

  always_comb begin
    sel_ow = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (active_addr == ADDR_W'(k)) sel_ow = ow_bus[24*k +: 24];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ena         <= '0;
      proj_rst_n  <= 1'b0;
      active_addr <= '0;
      addr_ready  <= 1'b1;
      addr_err    <= 1'b0;
      busy        <= 1'b0;
      pend_addr   <= '0;
      pend_ok     <= 1'b0;
      cnt         <= '0;
      uo_out      <= '0;
      uio_out     <= '0;
      uio_oe      <= '0;
    end else begin
      addr_err <= 1'b0;
      // Leaving RUN on this edge already zeroes the pads, so uio_oe never leaks into QUIESCE.
      if (state == RUN && !accept) {uio_oe, uio_out, uo_out} <= sel_ow;
      else                         {uio_oe, uio_out, uo_out} <= '0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (addr_ok) begin
              state       <= SWITCH;
              ena         <= onehot(addr_i);
              active_addr <= addr_i;
              addr_ready  <= 1'b0;
              busy        <= 1'b1;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            state      <= QUIESCE;
            pend_addr  <= addr_i;
            pend_ok    <= addr_ok;
            cnt        <= CNT_W'(RST_CYCLES - 1);
            proj_rst_n <= 1'b0;
            addr_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        QUIESCE: begin
          if (cnt == '0) begin
            if (pend_ok) begin
              // Direct old->new hand-off keeps ena one-hot on every cycle.
              state       <= SWITCH;
              ena         <= onehot(pend_addr);
              active_addr <= pend_addr;
            end else begin
              state      <= IDLE;
              ena        <= '0;
              addr_err   <= 1'b1;
              addr_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SWITCH: begin
          state <= RESET;
          cnt   <= CNT_W'(RST_CYCLES - 1);
        end
        RESET: begin
          if (cnt == '0) begin
            state      <= RUN;
            proj_rst_n <= 1'b1;
            addr_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          ena        <= '0;
          proj_rst_n <= 1'b0;
          addr_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_project_sel_ctrl.sv
// Directed bench for mux_project_sel_ctrl: a 32-project/RST_CYCLES=4 instance and a
// 4-project/RST_CYCLES=1 instance, checked against hand-computed expectations.
module tb_mux_project_sel_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   addr_i = '0;
  logic         addr_valid = 1'b0;
  logic         addr_ready, addr_err, busy;
  logic [5:0]   active_addr;
  logic [7:0]   ui_in = 8'h3C;
  logic [7:0]   uio_in = 8'hE1;
  logic [31:0]  ena;
  logic [17:0]  iw;
  logic [767:0] ow_bus;
  logic [7:0]   uo_out, uio_out, uio_oe;

  logic [1:0]   addr1 = '0;
  logic         valid1 = 1'b0;
  logic         ready1, err1, busy1;
  logic [1:0]   active1;
  logic [3:0]   ena1;
  logic [17:0]  iw1;
  logic [95:0]  ow_bus1;
  logic [7:0]   uo1, uio_out1, uio_oe1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_project_sel_ctrl #(.NUM_PROJ(32), .ADDR_W(6), .RST_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .addr_err(addr_err), .busy(busy), .active_addr(active_addr),
    .ui_in(ui_in), .uio_in(uio_in), .ena(ena), .iw(iw), .ow_bus(ow_bus),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  mux_project_sel_ctrl #(.NUM_PROJ(4), .ADDR_W(2), .RST_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .addr_i(addr1), .addr_valid(valid1),
    .addr_ready(ready1), .addr_err(err1), .busy(busy1), .active_addr(active1),
    .ui_in(ui_in), .uio_in(uio_in), .ena(ena1), .iw(iw1), .ow_bus(ow_bus1),
    .uo_out(uo1), .uio_out(uio_out1), .uio_oe(uio_oe1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    tests++; if (ena !== 32'h0) begin fails++; $display("FAIL reset_ena got=%h exp=%h", ena, 32'h0); end
    tests++; if (iw[1] !== 1'b0) begin fails++; $display("FAIL reset_rst_n got=%b exp=0", iw[1]); end
    tests++; if (addr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", addr_ready); end
    tests++; if ({addr_err, busy} !== 2'b00) begin fails++; $display("FAIL reset_err_busy got=%b exp=00", {addr_err, busy}); end
    tests++; if (active_addr !== 6'd0) begin fails++; $display("FAIL reset_active got=%0d exp=0", active_addr); end
    tests++; if ({uio_oe, uio_out, uo_out} !== 24'h0) begin fails++; $display("FAIL reset_pads got=%h exp=000000", {uio_oe, uio_out, uo_out}); end
    tests++; if (iw[17:2] !== 16'hE13C) begin fails++; $display("FAIL reset_iw_fwd got=%h exp=e13c", iw[17:2]); end
    tick;
    tick;
    rst = 1'b0;
    tick;
    $display("[TB] test_reset done");
  endtask

  task automatic test_select;
    addr_i = 6'd3; addr_valid = 1'b1;
    tick;
    addr_valid = 1'b0;
    tests++; if (ena !== 32'h8) begin fails++; $display("FAIL sel_switch_ena got=%h exp=%h", ena, 32'h8); end
    tests++; if ({busy, addr_ready} !== 2'b10) begin fails++; $display("FAIL sel_switch_busy_ready got=%b exp=10", {busy, addr_ready}); end
    tests++; if (active_addr !== 6'd3) begin fails++; $display("FAIL sel_active got=%0d exp=3", active_addr); end
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++; if ({iw[1], ena} !== {1'b0, 32'h8}) begin fails++; $display("FAIL sel_reset_phase%0d got rst_n=%b ena=%h exp rst_n=0 ena=8", i, iw[1], ena); end
    end
    tick;
    tests++; if ({iw[1], addr_ready, busy} !== 3'b110) begin fails++; $display("FAIL sel_run_entry got=%b exp=110", {iw[1], addr_ready, busy}); end
    tests++; if (uo_out !== 8'h00) begin fails++; $display("FAIL sel_run_first_pads got=%h exp=00", uo_out); end
    tick;
    tests++; if ({uio_oe, uio_out, uo_out} !== 24'hA55AC3) begin fails++; $display("FAIL sel_pads got=%h exp=a55ac3", {uio_oe, uio_out, uo_out}); end
    ow_bus[95:72] = 24'h123456;
    tests++; if (uo_out !== 8'hC3) begin fails++; $display("FAIL sel_pads_hold got=%h exp=c3", uo_out); end
    tick;
    tests++; if ({uio_oe, uio_out, uo_out} !== 24'h123456) begin fails++; $display("FAIL sel_pads_latency got=%h exp=123456", {uio_oe, uio_out, uo_out}); end
    $display("[TB] test_select done");
  endtask

  task automatic test_switch;
    addr_i = 6'd7; addr_valid = 1'b1;
    tick;
    addr_valid = 1'b0;
    addr_i = 6'd12;
    for (int i = 0; i < 4; i++) begin
      tests++; if ({iw[1], ena, uio_oe} !== {1'b0, 32'h8, 8'h00}) begin fails++; $display("FAIL sw_quiesce%0d got rst_n=%b ena=%h oe=%h exp 0/8/00", i, iw[1], ena, uio_oe); end
      tick;
    end
    tests++; if ({ena, active_addr} !== {32'h80, 6'd7}) begin fails++; $display("FAIL sw_switch got ena=%h act=%0d exp ena=80 act=7", ena, active_addr); end
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++; if ({iw[1], ena} !== {1'b0, 32'h80}) begin fails++; $display("FAIL sw_reset%0d got rst_n=%b ena=%h exp 0/80", i, iw[1], ena); end
    end
    tick;
    tests++; if (iw[1] !== 1'b1) begin fails++; $display("FAIL sw_run got rst_n=%b exp=1", iw[1]); end
    tick;
    tests++; if ({uio_oe, uio_out, uo_out} !== 24'h074787) begin fails++; $display("FAIL sw_pads got=%h exp=074787", {uio_oe, uio_out, uo_out}); end
    $display("[TB] test_switch done");
  endtask

  task automatic test_back_to_back;
    addr_i = 6'd5; addr_valid = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) begin
      tests++; if (addr_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_low%0d got=%b exp=0", i, addr_ready); end
      tick;
    end
    tests++; if ({addr_ready, iw[1], active_addr} !== {2'b11, 6'd5}) begin fails++; $display("FAIL b2b_run got=%b exp=%b", {addr_ready, iw[1], active_addr}, {2'b11, 6'd5}); end
    tick;
    addr_valid = 1'b0;
    tests++; if ({busy, addr_ready} !== 2'b10) begin fails++; $display("FAIL b2b_second_accept got=%b exp=10", {busy, addr_ready}); end
    for (int i = 0; i < 9; i++) tick;
    tests++; if ({iw[1], ena} !== {1'b1, 32'h20}) begin fails++; $display("FAIL b2b_rerun got rst_n=%b ena=%h exp 1/20", iw[1], ena); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_invalid_run;
    addr_i = 6'd40; addr_valid = 1'b1;
    tick;
    addr_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    tests++; if ({addr_err, ena} !== {1'b0, 32'h20}) begin fails++; $display("FAIL inv_run_quiesce got err=%b ena=%h exp 0/20", addr_err, ena); end
    tick;
    tests++; if ({addr_err, addr_ready, busy, ena} !== {3'b110, 32'h0}) begin fails++; $display("FAIL inv_run_idle got err/rdy/busy=%b ena=%h exp 110/0", {addr_err, addr_ready, busy}, ena); end
    tick;
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL inv_run_pulse got=%b exp=0", addr_err); end
    $display("[TB] test_invalid_run done");
  endtask

  task automatic test_invalid_idle;
    addr_i = 6'd40; addr_valid = 1'b1;
    tick;
    addr_valid = 1'b0;
    tests++; if ({addr_err, addr_ready, busy, ena} !== {3'b110, 32'h0}) begin fails++; $display("FAIL inv_idle got err/rdy/busy=%b ena=%h exp 110/0", {addr_err, addr_ready, busy}, ena); end
    tick;
    tests++; if ({addr_err, ena} !== {1'b0, 32'h0}) begin fails++; $display("FAIL inv_idle_pulse got err=%b ena=%h exp 0/0", addr_err, ena); end
    $display("[TB] test_invalid_idle done");
  endtask

  task automatic test_async_reset;
    addr_i = 6'd2; addr_valid = 1'b1;
    tick;
    addr_valid = 1'b0;
    tick;
    tick;
    tests++; if (ena !== 32'h4) begin fails++; $display("FAIL ar_pre got ena=%h exp=4", ena); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({ena, uio_oe, iw[1]} !== {32'h0, 8'h0, 1'b0}) begin fails++; $display("FAIL ar_async got ena=%h oe=%h rst_n=%b exp 0/00/0", ena, uio_oe, iw[1]); end
    tests++; if ({addr_ready, busy, active_addr} !== {2'b10, 6'd0}) begin fails++; $display("FAIL ar_async_ctrl got=%b exp=%b", {addr_ready, busy, active_addr}, {2'b10, 6'd0}); end
    tick;
    rst = 1'b0;
    tick;
    tick;
    tests++; if ({addr_ready, busy, ena} !== {2'b10, 32'h0}) begin fails++; $display("FAIL ar_idle got rdy/busy=%b ena=%h exp 10/0", {addr_ready, busy}, ena); end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_short_reset;
    addr1 = 2'd0; valid1 = 1'b1;
    tick;
    valid1 = 1'b0;
    tests++; if ({iw1[1], ena1} !== {1'b0, 4'b0001}) begin fails++; $display("FAIL sr_switch got rst_n=%b ena=%b exp 0/0001", iw1[1], ena1); end
    tick;
    tests++; if ({iw1[1], ena1} !== {1'b0, 4'b0001}) begin fails++; $display("FAIL sr_reset got rst_n=%b ena=%b exp 0/0001", iw1[1], ena1); end
    tick;
    tests++; if ({iw1[1], ena1, ready1} !== {1'b1, 4'b0001, 1'b1}) begin fails++; $display("FAIL sr_run got rst_n=%b ena=%b rdy=%b exp 1/0001/1", iw1[1], ena1, ready1); end
    tick;
    tests++; if ({uio_oe1, uio_out1, uo1} !== 24'h0FF03C) begin fails++; $display("FAIL sr_pads got=%h exp=0ff03c", {uio_oe1, uio_out1, uo1}); end
    $display("[TB] test_short_reset done");
  endtask

  initial begin
    for (int k = 0; k < 32; k++) ow_bus[24*k +: 24] = {8'(k), 8'(8'h40 + k), 8'(8'h80 + k)};
    ow_bus[95:72] = 24'hA55AC3;
    ow_bus1 = '0;
    ow_bus1[23:0] = 24'h0FF03C;
    ow_bus1[71:48] = 24'hFFFFFF;
    test_reset;
    test_select;
    test_switch;
    test_back_to_back;
    test_invalid_run;
    test_invalid_idle;
    test_async_reset;
    test_short_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
